kmeans_labeler: RTL and testbench
=================================

# kmeans_labeler

Downstream consumer of the k-means core. It captures the four final centroids that the core emits as four consecutive 16-bit words. It then labels a stream of DATA_SIZE points with the index of the nearest centroid (Manhattan distance) and outputs the winning centroid as the quantized point. It sits between the k-means core output and the image/write-back path, and turns converged centroids into per-point cluster assignments.

## Interface
- DATA_SIZE, 4096: number of points labeled per centroid set; a power of two, minimum 2.
- CLUSTER_SIZE, 4: number of centroids; fixed at 4, not overridable.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cent_valid  input  1  centroid word present; driven from the core's out_valid.
- cent_data  input  16  centroid, x in [15:8], y in [7:0], unsigned.
- pt_valid  input  1  point word present.
- pt_data  input  16  point, x in [15:8], y in [7:0], unsigned.
- pt_ready  output  1  point accepted when pt_valid && pt_ready.
- out_valid  output  1  label result valid, one-cycle qualifier per point.
- out_label  output  2  index of the nearest centroid.
- out_data  output  16  winning centroid value (quantized point).
- done  output  1  one-cycle pulse when the labeling pass is complete.
- hist_valid, hist_data[12:0]  output  only with LABELER_HIST_EN; see Configuration.

## Operation
- States: IDLE, LOAD, RUN, FLUSH, DONE, plus HIST (macro only).
- IDLE:
  - The first cycle with cent_valid high stores cent_data as centroid 0 and moves to LOAD.
  - pt_ready is 0.
- LOAD:
  - Each cent_valid cycle stores the next centroid (1, 2, 3).
  - Gaps in cent_valid are allowed; the load index holds through them.
  - After centroid 3 is stored, move to RUN. Points are not accepted in LOAD.
- RUN:
  - pt_ready is 1 until DATA_SIZE points have been accepted; a 12-bit accept counter wraps to 0 on the last accept.
  - The last accept moves to FLUSH, and pt_ready drops in the following cycle.
  - cent_valid is ignored in RUN, FLUSH, DONE and HIST.
- Per-point arithmetic:
  - dx = |px − cx| and dy = |py − cy|, each 8-bit unsigned.
  - dist = dx + dy, 9-bit, no overflow (max 510).
- Selection:
  - Strict less-than scan from index 0 to 3, so on ties the lowest index wins.
  - out_data is the stored centroid of the winning index.
- FLUSH: wait until all pipeline valid bits are clear, then move to DONE.
- DONE:
  - Assert done for one cycle.
  - Without the macro, go to IDLE; with it, go to HIST.
- Centroids are retained after DONE and cleared only by reset; a new IDLE→LOAD sequence overwrites them.
- Reset mid-operation:
  - All state returns to IDLE.
  - Pipeline valids, counters and centroids clear to 0.
  - Any in-flight points are discarded, with no out_valid for them.

## Timing
- Reset values: pt_ready=0, out_valid=0, out_label=0, out_data=0, done=0, hist_valid=0, hist_data=0.
- Pipeline is 3 stages with no stalls:
  - S1 registers the accepted point.
  - S2 registers the four 9-bit distances.
  - S3 registers label and centroid.
- Latency: a point accepted at edge N gives out_valid=1 in the cycle after edge N+2 (3-cycle latency).
- Throughput: one point per cycle. Output has no backpressure.
- Load timing:
  - cent_valid on 4 consecutive cycles puts the block in RUN on the cycle after the 4th word.
  - pt_ready rises in that same cycle.
- done is high in the cycle after the last out_valid.
- out_label and out_data hold their last values when out_valid=0.

## Configuration
- LABELER_HIST_EN defined:
  - Four 13-bit per-cluster hit counters, incremented on each out_valid by out_label and cleared on entry to RUN.
  - After DONE, the HIST state drives hist_valid for 4 consecutive cycles with hist_data = count0..count3, then returns to IDLE.
  - The counts always sum to DATA_SIZE.
- LABELER_HIST_EN undefined: no counters, no hist ports, and DONE returns directly to IDLE.

## Test plan
- Centroid loading and basic labeling:
  - Stimulus: load 0x1010, 0x1080, 0x8010, 0x8080 on consecutive cycles, then point 0x1212.
  - Response: out_label=0 and out_data=0x1010 exactly 3 cycles after accept.
  - Also point 0x7F7F: label 3, out_data 0x8080.
- Tie-break:
  - Stimulus: same centroids, point 0x4810 (distance 56 to both centroid 0 and centroid 2).
  - Response: out_label=0.
- Full pass with input gaps:
  - Stimulus: DATA_SIZE=16, pt_valid toggling randomly.
  - Response: exactly 16 out_valid pulses in accept order, pt_ready=0 after the 16th accept, done high one cycle after the last out_valid, state back to IDLE.
- Gapped centroid load:
  - Stimulus: cent_valid with 2-cycle gaps between words, and pt_valid held high throughout.
  - Response: no point is accepted before the 4th centroid, and the loaded centroids are correct.
- Reset mid-RUN:
  - Stimulus: assert rst_n low asynchronously with 2 points in flight.
  - Response: all outputs go to 0 immediately, no stale out_valid after release, state is IDLE.
- LABELER_HIST_EN:
  - Stimulus: 16 points split 5/3/8/0 across the clusters.
  - Response: hist_data = 5, 3, 8, 0 on 4 consecutive hist_valid cycles.

Source files
------------

// File: rtl/kmeans_labeler.sv
// Nearest-centroid labeler: captures four centroids, then labels DATA_SIZE points (Manhattan
// distance). Per-cluster hit histogram is built only when LABELER_HIST_EN is defined.
module kmeans_labeler #(
    parameter int unsigned DATA_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cent_valid,
    input  logic [15:0] cent_data,
    input  logic        pt_valid,
    input  logic [15:0] pt_data,
    output logic        pt_ready,
    output logic        out_valid,
    output logic [1:0]  out_label,
    output logic [15:0] out_data,
    output logic        done
`ifdef LABELER_HIST_EN
    ,
    output logic        hist_valid,
    output logic [12:0] hist_data
`endif
);

    localparam int unsigned CLUSTER_SIZE = 4;
    localparam int unsigned CntW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StFlush, StDone, StHist} state_e;

    state_e state_q, state_d;

    logic [1:0]      load_idx_q;
    logic [CntW-1:0] acc_cnt_q;
    logic [15:0]     cent_q [CLUSTER_SIZE];

    logic        s1_valid_q;
    logic [15:0] s1_pt_q;
    logic        s2_valid_q;
    logic [8:0]  s2_dist_q [CLUSTER_SIZE];
    logic [8:0]  dist_d [CLUSTER_SIZE];
    logic        out_valid_q;
    logic [1:0]  out_label_q;
    logic [15:0] out_data_q;

    logic       accept;
    logic       last_acc;
    logic [1:0] best_idx;
    logic [8:0] best_dist;

`ifdef LABELER_HIST_EN
    logic [12:0] hist_cnt_q [CLUSTER_SIZE];
    logic [1:0]  hist_idx_q;
`endif

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign pt_ready = (state_q == StRun);
    assign accept   = pt_valid && pt_ready;
    assign last_acc = (acc_cnt_q == CntW'(DATA_SIZE - 1));

    // The output stage holds the final result in the same cycle that S1/S2 drain, so DONE
    // follows directly and done lands in the cycle after the last out_valid.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cent_valid) state_d = StLoad;
            StLoad:  if (cent_valid && load_idx_q == 2'd3) state_d = StRun;
            StRun:   if (accept && last_acc) state_d = StFlush;
            StFlush: if (!s1_valid_q && !s2_valid_q) state_d = StDone;
`ifdef LABELER_HIST_EN
            StDone:  state_d = StHist;
            StHist:  if (hist_idx_q == 2'd3) state_d = StIdle;
`else
            StDone:  state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            load_idx_q <= 2'd0;
            acc_cnt_q  <= '0;
            for (int i = 0; i < CLUSTER_SIZE; i++) cent_q[i] <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cent_valid) begin
                cent_q[0]  <= cent_data;
                load_idx_q <= 2'd1;
            end else if (state_q == StLoad && cent_valid) begin
                cent_q[load_idx_q] <= cent_data;
                load_idx_q         <= load_idx_q + 2'd1;
            end
            if (accept) acc_cnt_q <= last_acc ? '0 : acc_cnt_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < CLUSTER_SIZE; i++) begin
            dist_d[i] = {1'b0, abs_diff(s1_pt_q[15:8], cent_q[i][15:8])}
                      + {1'b0, abs_diff(s1_pt_q[7:0], cent_q[i][7:0])};
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx  = 2'd0;
        best_dist = s2_dist_q[0];
        for (int i = 1; i < CLUSTER_SIZE; i++) begin
            if (s2_dist_q[i] < best_dist) begin
                best_dist = s2_dist_q[i];
                best_idx  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_pt_q     <= 16'd0;
            s2_valid_q  <= 1'b0;
            for (int i = 0; i < CLUSTER_SIZE; i++) s2_dist_q[i] <= 9'd0;
            out_valid_q <= 1'b0;
            out_label_q <= 2'd0;
            out_data_q  <= 16'd0;
        end else begin
            s1_valid_q <= accept;
            if (accept) s1_pt_q <= pt_data;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < CLUSTER_SIZE; i++) s2_dist_q[i] <= dist_d[i];
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_label_q <= best_idx;
                out_data_q  <= cent_q[best_idx];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_label = out_label_q;
    assign out_data  = out_data_q;
    assign done      = (state_q == StDone);

`ifdef LABELER_HIST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLUSTER_SIZE; i++) hist_cnt_q[i] <= 13'd0;
            hist_idx_q <= 2'd0;
        end else begin
            if (state_d == StRun && state_q != StRun) begin
                for (int i = 0; i < CLUSTER_SIZE; i++) hist_cnt_q[i] <= 13'd0;
            end else if (out_valid_q) begin
                hist_cnt_q[out_label_q] <= hist_cnt_q[out_label_q] + 13'd1;
            end
            hist_idx_q <= (state_q == StHist) ? hist_idx_q + 2'd1 : 2'd0;
        end
    end

    assign hist_valid = (state_q == StHist);
    assign hist_data  = hist_valid ? hist_cnt_q[hist_idx_q] : 13'd0;
`endif

endmodule

// File: tb/tb_kmeans_labeler.sv
// Randomized bench for kmeans_labeler with a nearest-centroid reference model and scoreboard.
// Histogram checks are compiled in when LABELER_HIST_EN is defined.
module tb_kmeans_labeler;

    localparam int DS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cent_valid;
    logic [15:0] cent_data;
    logic        pt_valid;
    logic [15:0] pt_data;
    logic        pt_ready;
    logic        out_valid;
    logic [1:0]  out_label;
    logic [15:0] out_data;
    logic        done;
`ifdef LABELER_HIST_EN
    logic        hist_valid;
    logic [12:0] hist_data;
`endif

    kmeans_labeler #(.DATA_SIZE(DS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cent_valid (cent_valid),
        .cent_data  (cent_data),
        .pt_valid   (pt_valid),
        .pt_data    (pt_data),
        .pt_ready   (pt_ready),
        .out_valid  (out_valid),
        .out_label  (out_label),
        .out_data   (out_data),
        .done       (done)
`ifdef LABELER_HIST_EN
        ,
        .hist_valid (hist_valid),
        .hist_data  (hist_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] pts [DS];
    logic [15:0] model_cent [4];
    logic [17:0] exp_q [$];
    int          acc_q [$];
    int          out_cnt, done_cnt, done_base, last_out_cyc;
    int          hist_model [4];
    int          hist_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Nearest centroid by Manhattan distance; first minimum wins.
    function automatic logic [17:0] nearest(input logic [15:0] p);
        int best = 0;
        int bd   = 1 << 20;
        for (int k = 0; k < 4; k++) begin
            int d;
            logic [15:0] c;
            c = model_cent[k];
            d = adiff(int'(p[15:8]), int'(c[15:8])) + adiff(int'(p[7:0]), int'(c[7:0]));
            if (d < bd) begin
                bd   = d;
                best = k;
            end
        end
        return {2'(best), model_cent[best]};
    endfunction

    function automatic logic [7:0] jit(input logic [7:0] base);
        return 8'(int'(base) + int'($urandom_range(0, 15)));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: outputs checked against queued expectations, accepts enqueue the model result.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("stale_out", 32'(out_valid), 32'd0);
            end else begin
                logic [17:0] e;
                int          a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("label", 32'(out_label), 32'(e[17:16]));
                check("data", 32'(out_data), 32'(e[15:0]));
                check("latency", 32'(cyc), 32'(a + 3));
            end
            out_cnt++;
            last_out_cyc = cyc;
        end
        if (done) begin
            check("done_timing", 32'(cyc), 32'(last_out_cyc + 1));
            done_cnt++;
        end
`ifdef LABELER_HIST_EN
        if (hist_valid) begin
            if (hist_seen >= 4) check("hist_extra", 32'(hist_valid), 32'd0);
            else check("hist_data", 32'(hist_data), 32'(hist_model[hist_seen]));
            hist_seen++;
        end
`endif
        if (rst_n && pt_valid && pt_ready) begin
            logic [17:0] e;
            e = nearest(pt_data);
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            hist_model[e[17:16]]++;
        end
    end

    task automatic pass_begin();
        out_cnt   = 0;
        done_base = done_cnt;
        hist_seen = 0;
        for (int k = 0; k < 4; k++) hist_model[k] = 0;
    endtask

    task automatic load_cents(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3,
                              input int gap, input bit hold_pt);
        logic [15:0] w [4];
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        for (int k = 0; k < 4; k++) model_cent[k] = w[k];
        pass_begin();
        if (hold_pt) begin
            pt_valid = 1'b1;
            pt_data  = pts[0];
        end
        for (int k = 0; k < 4; k++) begin
            cent_valid = 1'b1;
            cent_data  = w[k];
            @(negedge clk);
            check("ready_in_load", 32'(pt_ready), 32'd0);
            @(posedge clk); #1;
            cent_valid = 1'b0;
            if (k < 3) begin
                repeat (gap) begin
                    @(negedge clk);
                    check("ready_in_gap", 32'(pt_ready), 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
        @(negedge clk);
        check("ready_after_load", 32'(pt_ready), 32'd1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
    endtask

    task automatic run_points(input int start, input int stop, input bit gaps);
        int idx   = start;
        int guard = 0;
        while (idx < stop && guard < 400) begin
            pt_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pt_data  = pts[idx];
            if (gaps) begin
                cent_valid = 1'($urandom_range(0, 1));
                cent_data  = 16'($urandom);
            end
            @(negedge clk);
            if (pt_valid && pt_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        pt_valid   = 1'b0;
        cent_valid = 1'b0;
        if (idx < stop) check("accept_timeout", 32'(idx), 32'(stop));
    endtask

    task automatic finish_pass();
        int g = 0;
        @(negedge clk);
        check("ready_after_last", 32'(pt_ready), 32'd0);
        while (done_cnt == done_base && g < 64) begin
            @(negedge clk);
            g++;
        end
        repeat (8) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("out_count", 32'(out_cnt), 32'(DS));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_ready", 32'(pt_ready), 32'd0);
`ifdef LABELER_HIST_EN
        check("hist_beats", 32'(hist_seen), 32'd4);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        cent_valid = 1'b0;
        cent_data  = 16'd0;
        pt_valid   = 1'b0;
        pt_data    = 16'd0;
        done_cnt   = 0;
        last_out_cyc = -10;
        pass_begin();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_label", 32'(out_label), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef LABELER_HIST_EN
        check("rst_hist_valid", 32'(hist_valid), 32'd0);
        check("rst_hist_data", 32'(hist_data), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed points first (basic, far corner, tie), then random, with input gaps.
        for (int i = 0; i < DS; i++) pts[i] = 16'($urandom);
        pts[0] = 16'h1212;
        pts[1] = 16'h7F7F;
        pts[2] = 16'h4810;
        load_cents(16'h1010, 16'h1080, 16'h8010, 16'h8080, 0, 1'b0);
        run_points(0, DS, 1'b1);
        finish_pass();

        // Gapped centroid load with pt_valid held high; first point taken on RUN entry.
        for (int i = 0; i < DS; i++) pts[i] = 16'($urandom);
        load_cents(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2, 1'b1);
        run_points(1, DS, 1'b0);
        finish_pass();

        // Asynchronous reset with two points in flight.
        for (int i = 0; i < DS; i++) pts[i] = 16'($urandom);
        load_cents(16'h2030, 16'hC040, 16'h50E0, 16'hF0F0, 0, 1'b0);
        run_points(0, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_label", 32'(out_label), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_pt_ready", 32'(pt_ready), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("arst_idle_ready", 32'(pt_ready), 32'd0);
        check("arst_no_outputs", 32'(exp_q.size()), 32'd0);

        // 5/3/8/0 split across the clusters.
        for (int i = 0; i < DS; i++) begin
            if (i < 5)      pts[i] = {jit(8'h10), jit(8'h10)};
            else if (i < 8) pts[i] = {jit(8'h10), jit(8'h80)};
            else            pts[i] = {jit(8'h80), jit(8'h10)};
        end
        load_cents(16'h1010, 16'h1080, 16'h8010, 16'h8080, 0, 1'b0);
        run_points(0, DS, 1'b1);
        finish_pass();
        check("split_c0", 32'(hist_model[0]), 32'd5);
        check("split_c2", 32'(hist_model[2]), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
